// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter that shares the single system-memory
// port among PROCS cores. One core is granted at a time; its load or store is
// issued as a one-cycle strobe, the arbiter waits for mem_resp, pulses done to
// the granted core and re-arbitrates.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT cycles, reporting done together with err to the granted core.
module mem_bus_arbiter #(
  parameter int PROCS   = 4,
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PROCS-1:0]        req,
  input  logic [PROCS-1:0]        is_store,
  input  logic [PROCS*ADDR_W-1:0] addr,
  input  logic [PROCS*16-1:0]     wdata,
  output logic [PROCS-1:0]        grant,
  output logic [PROCS-1:0]        done,
  output logic [PROCS-1:0]        err,
  output logic [7:0]              rdata,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [15:0]             mem_wdata,
  output logic                    mem_read_req,
  output logic                    mem_write_req,
  input  logic [7:0]              mem_rdata,
  input  logic                    mem_resp
);

  localparam int PW = (PROCS > 1) ? $clog2(PROCS) : 1;
  localparam logic [PW-1:0] PTR_RESET = PW'(PROCS - 1);

  // Reject configurations outside the supported range at elaboration time
  if (PROCS < 2 || PROCS > 8 || TIMEOUT < 1) begin : gBadParams
    $error("mem_bus_arbiter: PROCS must be 2..8 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     winner_q, winner_d;
  logic              store_q, store_d;
  logic [PROCS-1:0]  grant_q, grant_d;
  logic [PROCS-1:0]  done_q, done_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [15:0]       memWdata_q, memWdata_d;
  logic              readReq_q, readReq_d;
  logic              writeReq_q, writeReq_d;

  logic [PW-1:0]     winSel;
  logic [PW-1:0]     candIdx;
  logic              anyReq;
  logic              timeoutHit;
  int                cand;

  logic [ADDR_W-1:0] addrArr  [PROCS];
  logic [15:0]       wdataArr [PROCS];

  for (genvar g = 0; g < PROCS; g++) begin : gUnpack
    assign addrArr[g]  = addr[g*ADDR_W +: ADDR_W];
    assign wdataArr[g] = wdata[g*16 +: 16];
  end

  // Rotating search upward from the slot after the last-served core
  always_comb begin
    winSel  = ptr_q;
    anyReq  = 1'b0;
    cand    = 0;
    candIdx = '0;
    for (int k = 1; k <= PROCS; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= PROCS) cand = cand - PROCS;
      candIdx = PW'(cand);
      if (!anyReq && req[candIdx]) begin
        winSel = candIdx;
        anyReq = 1'b1;
      end
    end
  end

  // State and registered-output update; reset abandons any in-flight access
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= PTR_RESET;
      winner_q   <= '0;
      store_q    <= 1'b0;
      grant_q    <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      readReq_q  <= 1'b0;
      writeReq_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      winner_q   <= winner_d;
      store_q    <= store_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      readReq_q  <= readReq_d;
      writeReq_q <= writeReq_d;
    end
  end

  // Next-state sequencing through IDLE -> ISSUE -> WAIT -> DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (anyReq) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (mem_resp || timeoutHit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; strobes and done default low
  always_comb begin
    ptr_d      = ptr_q;
    winner_d   = winner_q;
    store_d    = store_q;
    grant_d    = grant_q;
    done_d     = '0;
    rdata_d    = rdata_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    readReq_d  = 1'b0;
    writeReq_d = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (anyReq) begin
          grant_d[winSel] = 1'b1;
          winner_d        = winSel;
          store_d         = is_store[winSel];
          memAddr_d       = addrArr[winSel];
          memWdata_d      = wdataArr[winSel];
          writeReq_d      = is_store[winSel];
          readReq_d       = !is_store[winSel];
        end
      end
      ISSUE: begin
      end
      WAIT: begin
        if (mem_resp || timeoutHit) done_d[winner_q] = 1'b1;
        if (mem_resp && !store_q) rdata_d = mem_rdata;
      end
      DONE: begin
        grant_d = '0;
        ptr_d   = winner_q;
      end
      default: begin
      end
    endcase
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0]    waitCnt_q, waitCnt_d;
  logic [PROCS-1:0] err_q, err_d;

  assign timeoutHit = (state_q == WAIT) && (waitCnt_q == CW'(TIMEOUT - 1));

  // Count WAIT cycles from zero; abort flag only when no response arrived
  always_comb begin
    waitCnt_d = '0;
    err_d     = '0;
    if (state_q == WAIT) begin
      waitCnt_d = waitCnt_q + 1'b1;
      if (!mem_resp && timeoutHit) err_d[winner_q] = 1'b1;
    end
  end

  // Timeout counter and abort flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      waitCnt_q <= '0;
      err_q     <= '0;
    end else begin
      waitCnt_q <= waitCnt_d;
      err_q     <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeoutHit = 1'b0;
  assign err        = '0;
`endif

  assign grant         = grant_q;
  assign done          = done_q;
  assign rdata         = rdata_q;
  assign mem_addr      = memAddr_q;
  assign mem_wdata     = memWdata_q;
  assign mem_read_req  = readReq_q;
  assign mem_write_req = writeReq_q;

endmodule
